// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Each cycle it picks one of advance, stall, redirect or fault, and drives the
// PC-update and latch-control strobes for ifetch. The strobes are combinational
// (Mealy). The fault record and the stall counter are registered.
module ifetch_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                PC_STEP     = 4,
  parameter logic [2:0]        ROM_DID     = 3'd0,
  parameter int                BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_curr,
  input  logic              hit,
  input  logic [2:0]        did,
  input  logic              valid,
  input  logic              dec_stall,
  input  logic              redir_req,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic              fault_clr,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              hold,
  output logic              flush,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [1:0]        fault_cause,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_STALL,
    ST_REDIR,
    ST_FAULT
  } state_t;

  localparam logic [3:0]        BOOT_LAST      = 4'(BOOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STEP           = ADDR_W'(PC_STEP);
  localparam logic [1:0]        CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0]        CAUSE_DEVICE   = 2'b10;
  localparam logic [1:0]        CAUSE_ALIGN    = 2'b11;

  state_t              state_reg, state_next;
  logic [3:0]          boot_cnt_reg, boot_cnt_next;
  logic                fault_reg;
  logic [1:0]          fault_cause_reg;
  logic [ADDR_W-1:0]   fault_pc_reg;
  logic [15:0]         stall_cnt_reg;

  logic                redir_bad;
  logic                chk_fault;
  logic [1:0]          chk_cause;
  logic [ADDR_W-1:0]   chk_pc;
  logic                fault_take;
  logic                fault_exit;

  assign redir_bad = (redir_pc[1:0] != 2'b00);

  // Fault classification in FETCH priority order; a redirect masks the
  // fetch-side checks and can only fault on its own target alignment.
  always_comb begin
    chk_fault = 1'b0;
    chk_cause = 2'b00;
    chk_pc    = pc_curr;
    if (redir_req) begin
      if (redir_bad) begin
        chk_fault = 1'b1;
        chk_cause = CAUSE_ALIGN;
        chk_pc    = redir_pc;
      end
    end else if (valid && (pc_curr[1:0] != 2'b00)) begin
      chk_fault = 1'b1;
      chk_cause = CAUSE_ALIGN;
    end else if (valid && !hit) begin
      chk_fault = 1'b1;
      chk_cause = CAUSE_UNMAPPED;
    end else if (valid && (did != ROM_DID)) begin
      chk_fault = 1'b1;
      chk_cause = CAUSE_DEVICE;
    end
  end

  // Next-state and Mealy strobes.
  always_comb begin
    pc_we         = 1'b0;
    pc_next       = pc_curr;
    hold          = 1'b0;
    flush         = 1'b0;
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    fault_take    = 1'b0;
    fault_exit    = 1'b0;
    case (state_reg)
      ST_BOOT: begin
        hold  = 1'b1;
        flush = 1'b1;
        if (boot_cnt_reg == BOOT_LAST) begin
          // rst is active-low: no PC load while reset is still held
          pc_we         = rst;
          pc_next       = RESET_PC;
          boot_cnt_next = 4'd0;
          state_next    = ST_FETCH;
        end else begin
          boot_cnt_next = boot_cnt_reg + 4'd1;
        end
      end
      ST_FETCH, ST_STALL: begin
        if ((state_reg == ST_STALL) && !redir_req && dec_stall) begin
          hold = 1'b1;
        end else if (redir_req && !redir_bad) begin
          pc_we      = 1'b1;
          pc_next    = redir_pc;
          flush      = 1'b1;
          state_next = ST_REDIR;
        end else if (chk_fault) begin
          hold       = 1'b1;
          flush      = 1'b1;
          fault_take = 1'b1;
          state_next = ST_FAULT;
        end else if (dec_stall) begin
          hold       = 1'b1;
          state_next = ST_STALL;
        end else if (valid) begin
          pc_we      = 1'b1;
          pc_next    = pc_curr + STEP;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_REDIR: begin
        // refetch cycle at the new PC; a newer redirect replaces the old one
        hold       = 1'b1;
        state_next = ST_FETCH;
        if (redir_req) begin
          if (redir_bad) begin
            flush      = 1'b1;
            fault_take = 1'b1;
            state_next = ST_FAULT;
          end else begin
            pc_we      = 1'b1;
            pc_next    = redir_pc;
            flush      = 1'b1;
            state_next = ST_REDIR;
          end
        end
      end
      ST_FAULT: begin
        hold = 1'b1;
        if (fault_clr) begin
          pc_we      = 1'b1;
          pc_next    = redir_req ? redir_pc : RESET_PC;
          flush      = 1'b1;
          fault_exit = 1'b1;
          state_next = ST_REDIR;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State register and boot counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_BOOT;
      boot_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
    end
  end

  // Fault record: captured on fault entry, flag/cause dropped on clear, PC kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_reg       <= 1'b0;
      fault_cause_reg <= 2'b00;
      fault_pc_reg    <= '0;
    end else if (fault_take) begin
      fault_reg       <= 1'b1;
      fault_cause_reg <= chk_cause;
      fault_pc_reg    <= chk_pc;
    end else if (fault_exit) begin
      fault_reg       <= 1'b0;
      fault_cause_reg <= 2'b00;
    end
  end

  // Saturating count of edges spent in STALL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 16'd0;
    end else if ((state_reg == ST_STALL) && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign fault       = fault_reg;
  assign fault_cause = fault_cause_reg;
  assign fault_pc    = fault_pc_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed vector table, hand sequence for reset mid-stall,
// and a randomized run against a behavioural model of the fetch rules.
module tb_ifetch_ctrl;

  localparam int          ADDR_W      = 32;
  localparam logic [31:0] RESET_PC    = 32'h0;
  localparam int          PC_STEP     = 4;
  localparam logic [2:0]  ROM_DID     = 3'd0;
  localparam int          BOOT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_curr, redir_pc;
  logic        hit, valid, dec_stall, redir_req, fault_clr;
  logic [2:0]  did;
  logic        pc_we, hold, flush, fault;
  logic [31:0] pc_next, fault_pc;
  logic [1:0]  fault_cause;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  ifetch_ctrl #(
    .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP),
    .ROM_DID(ROM_DID), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .pc_curr(pc_curr), .hit(hit), .did(did),
    .valid(valid), .dec_stall(dec_stall), .redir_req(redir_req),
    .redir_pc(redir_pc), .fault_clr(fault_clr), .pc_we(pc_we),
    .pc_next(pc_next), .hold(hold), .flush(flush), .fault(fault),
    .fault_pc(fault_pc), .fault_cause(fault_cause), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        hit;
    logic [2:0]  did;
    logic        valid, stall, rq;
    logic [31:0] rpc;
    logic        clr;
    logic        we;
    logic [31:0] nxt;
    logic        hold, flush, fault;
    logic [1:0]  cause;
    logic [31:0] fpc;
    logic [15:0] scnt;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic [31:0] pc, logic h, logic [2:0] d, logic v, logic s, logic rq,
    logic [31:0] rpc, logic c, logic we, logic [31:0] nxt, logic hd, logic fl,
    logic f, logic [1:0] ca, logic [31:0] fpc, logic [15:0] sc);
    vec_t t;
    t.rst = r; t.pc = pc; t.hit = h; t.did = d; t.valid = v; t.stall = s;
    t.rq = rq; t.rpc = rpc; t.clr = c; t.we = we; t.nxt = nxt; t.hold = hd;
    t.flush = fl; t.fault = f; t.cause = ca; t.fpc = fpc; t.scnt = sc;
    return t;
  endfunction

  vec_t vecs[28];

  task automatic set_in(input logic r, input logic [31:0] pc, input logic h,
                        input logic [2:0] d, input logic v, input logic s,
                        input logic rq, input logic [31:0] rpc, input logic c);
    rst = r; pc_curr = pc; hit = h; did = d; valid = v; dec_stall = s;
    redir_req = rq; redir_pc = rpc; fault_clr = c;
  endtask

  // ---------------- behavioural reference model ----------------
  string       m_mode;
  int          m_boot;
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_fpc;
  int          m_scnt;
  logic        e_we, e_hold, e_flush;
  logic [31:0] e_nxt;
  string       n_mode;
  logic        n_take, n_clear;
  logic [1:0]  n_cause;
  logic [31:0] n_fpc;

  // What the fetch rules say about the current inputs, highest priority first.
  function automatic string classify();
    if (redir_req) return (redir_pc % 4 != 0) ? "BADJUMP" : "JUMP";
    if (valid && (pc_curr % 4 != 0)) return "MISALIGN";
    if (valid && !hit) return "UNMAPPED";
    if (valid && did != ROM_DID) return "DEVICE";
    if (dec_stall) return "STALL";
    if (valid) return "ADVANCE";
    return "IDLE";
  endfunction

  task automatic model_fault(input logic [1:0] cause, input logic [31:0] where);
    e_hold = 1; e_flush = 1; n_mode = "FAULT";
    n_take = 1; n_cause = cause; n_fpc = where;
  endtask

  task automatic model_eval();
    string act;
    if (!rst) begin
      m_mode = "BOOT"; m_boot = 0; m_fault = 0; m_cause = 0; m_fpc = 0; m_scnt = 0;
    end
    e_we = 0; e_nxt = pc_curr; e_hold = 0; e_flush = 0;
    n_mode = m_mode; n_take = 0; n_clear = 0; n_cause = 0; n_fpc = 0;
    act = classify();
    if (m_mode == "BOOT") begin
      e_hold = 1; e_flush = 1;
      if (m_boot == BOOT_CYCLES - 1) begin
        e_we = rst; e_nxt = RESET_PC; n_mode = "FETCH";
      end
    end else if (m_mode == "FAULT") begin
      e_hold = 1;
      if (fault_clr) begin
        e_we = 1; e_flush = 1; n_mode = "REDIR"; n_clear = 1;
        e_nxt = redir_req ? redir_pc : RESET_PC;
      end
    end else if (m_mode == "REDIR") begin
      e_hold = 1; n_mode = "FETCH";
      if (act == "BADJUMP") model_fault(2'b11, redir_pc);
      else if (act == "JUMP") begin
        e_we = 1; e_nxt = redir_pc; e_flush = 1; n_mode = "REDIR";
      end
    end else begin
      if (m_mode == "STALL" && dec_stall && act != "JUMP" && act != "BADJUMP")
        act = "STALL";
      n_mode = "FETCH";
      if (act == "BADJUMP") model_fault(2'b11, redir_pc);
      else if (act == "MISALIGN") model_fault(2'b11, pc_curr);
      else if (act == "UNMAPPED") model_fault(2'b01, pc_curr);
      else if (act == "DEVICE") model_fault(2'b10, pc_curr);
      else if (act == "JUMP") begin
        e_we = 1; e_nxt = redir_pc; e_flush = 1; n_mode = "REDIR";
      end else if (act == "STALL") begin
        e_hold = 1; n_mode = "STALL";
      end else if (act == "ADVANCE") begin
        e_we = 1; e_nxt = pc_curr + PC_STEP;
      end
    end
  endtask

  task automatic model_commit();
    if (!rst) return;
    if (m_mode == "STALL" && m_scnt < 65535) m_scnt++;
    if (m_mode == "BOOT") m_boot = (n_mode == "FETCH") ? 0 : m_boot + 1;
    if (n_take) begin
      m_fault = 1; m_cause = n_cause; m_fpc = n_fpc;
    end else if (n_clear) begin
      m_fault = 0; m_cause = 0;
    end
    m_mode = n_mode;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //                 rst pc            h  d  v  s  rq rpc        c  we nxt          hd fl f  ca fpc         scnt
    vecs[0]  = mk(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 1, 0, 0, 32'h0,    0);
    vecs[1]  = mk(0, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 1, 0, 0, 32'h0,    0);
    vecs[2]  = mk(1, 32'h0,        1, 0, 0, 1, 1, 32'h40,  0, 0, 32'h0,       1, 1, 0, 0, 32'h0,    0);
    vecs[3]  = mk(1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 1, 32'h0,       1, 1, 0, 0, 32'h0,    0);
    vecs[4]  = mk(1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       0, 0, 0, 0, 32'h0,    0);
    vecs[5]  = mk(1, 32'h0,        1, 0, 1, 0, 0, 32'h0,   0, 1, 32'h4,       0, 0, 0, 0, 32'h0,    0);
    vecs[6]  = mk(1, 32'h4,        1, 0, 1, 0, 0, 32'h0,   0, 1, 32'h8,       0, 0, 0, 0, 32'h0,    0);
    vecs[7]  = mk(1, 32'h8,        1, 0, 1, 0, 0, 32'h0,   0, 1, 32'hC,       0, 0, 0, 0, 32'h0,    0);
    vecs[8]  = mk(1, 32'hFFFFFFFC, 1, 0, 1, 0, 0, 32'h0,   0, 1, 32'h0,       0, 0, 0, 0, 32'h0,    0);
    vecs[9]  = mk(1, 32'h0,        1, 0, 1, 1, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h0,    0);
    vecs[10] = mk(1, 32'h0,        1, 0, 1, 1, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h0,    0);
    vecs[11] = mk(1, 32'h0,        1, 0, 1, 1, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h0,    1);
    vecs[12] = mk(1, 32'h0,        1, 0, 0, 0, 1, 32'h100, 0, 1, 32'h100,     0, 1, 0, 0, 32'h0,    2);
    vecs[13] = mk(1, 32'h100,      1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h100,     1, 0, 0, 0, 32'h0,    3);
    vecs[14] = mk(1, 32'h100,      1, 0, 1, 0, 0, 32'h0,   0, 1, 32'h104,     0, 0, 0, 0, 32'h0,    3);
    vecs[15] = mk(1, 32'h2000,     0, 0, 1, 0, 0, 32'h0,   0, 0, 32'h2000,    1, 1, 0, 0, 32'h0,    3);
    vecs[16] = mk(1, 32'h2000,     0, 0, 1, 0, 0, 32'h0,   0, 0, 32'h2000,    1, 0, 1, 1, 32'h2000, 3);
    vecs[17] = mk(1, 32'h2000,     0, 0, 1, 0, 0, 32'h0,   1, 1, 32'h0,       1, 1, 1, 1, 32'h2000, 3);
    vecs[18] = mk(1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h2000, 3);
    vecs[19] = mk(1, 32'h0,        1, 0, 0, 0, 1, 32'h102, 0, 0, 32'h0,       1, 1, 0, 0, 32'h2000, 3);
    vecs[20] = mk(1, 32'h0,        1, 0, 0, 0, 1, 32'h200, 1, 1, 32'h200,     1, 1, 1, 3, 32'h102,  3);
    vecs[21] = mk(1, 32'h200,      1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h200,     1, 0, 0, 0, 32'h102,  3);
    vecs[22] = mk(1, 32'h201,      1, 0, 1, 0, 0, 32'h0,   0, 0, 32'h201,     1, 1, 0, 0, 32'h102,  3);
    vecs[23] = mk(1, 32'h201,      1, 0, 1, 0, 0, 32'h0,   1, 1, 32'h0,       1, 1, 1, 3, 32'h201,  3);
    vecs[24] = mk(1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h201,  3);
    vecs[25] = mk(1, 32'h300,      1, 2, 1, 0, 0, 32'h0,   0, 0, 32'h300,     1, 1, 0, 0, 32'h201,  3);
    vecs[26] = mk(1, 32'h300,      1, 2, 1, 0, 0, 32'h0,   1, 1, 32'h0,       1, 1, 1, 2, 32'h300,  3);
    vecs[27] = mk(1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h0,       1, 0, 0, 0, 32'h300,  3);

    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 28; i++) begin
      set_in(vecs[i].rst, vecs[i].pc, vecs[i].hit, vecs[i].did, vecs[i].valid,
             vecs[i].stall, vecs[i].rq, vecs[i].rpc, vecs[i].clr);
      @(negedge clk);
      $display("vec %0d pc=%h we=%b nxt=%h hold=%b flush=%b fault=%b cause=%0d fpc=%h scnt=%0d",
               i, pc_curr, pc_we, pc_next, hold, flush, fault, fault_cause, fault_pc, stall_cnt);
      chk($sformatf("v%0d_we", i), 32'(pc_we), 32'(vecs[i].we));
      if (vecs[i].rst) chk($sformatf("v%0d_nxt", i), pc_next, vecs[i].nxt);
      chk($sformatf("v%0d_hold", i), 32'(hold), 32'(vecs[i].hold));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].flush));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].fault));
      chk($sformatf("v%0d_cause", i), 32'(fault_cause), 32'(vecs[i].cause));
      chk($sformatf("v%0d_fpc", i), fault_pc, vecs[i].fpc);
      chk($sformatf("v%0d_scnt", i), 32'(stall_cnt), 32'(vecs[i].scnt));
      @(posedge clk); #1;
    end

    // reset in the middle of a stall
    set_in(1, 32'h0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    $display("mid-stall before reset: hold=%b scnt=%0d", hold, stall_cnt);
    chk("ms_scnt5", 32'(stall_cnt), 32'd5);
    chk("ms_hold", 32'(hold), 32'd1);
    rst = 0;
    #1;
    $display("mid-stall after reset: we=%b hold=%b flush=%b fault=%b scnt=%0d", pc_we, hold, flush, fault, stall_cnt);
    chk("ms_rst_scnt", 32'(stall_cnt), 32'd0);
    chk("ms_rst_we", 32'(pc_we), 32'd0);
    chk("ms_rst_hold", 32'(hold), 32'd1);
    chk("ms_rst_flush", 32'(flush), 32'd1);
    chk("ms_rst_fault", 32'(fault), 32'd0);
    chk("ms_rst_fpc", fault_pc, 32'd0);
    chk("ms_rst_cause", 32'(fault_cause), 32'd0);
    @(posedge clk); #1;
    set_in(1, 32'h0, 1, 0, 1, 1, 1, 32'h40, 0);
    @(negedge clk);
    $display("reboot cycle 1: we=%b hold=%b flush=%b", pc_we, hold, flush);
    chk("rb1_we", 32'(pc_we), 32'd0);
    chk("rb1_hold", 32'(hold), 32'd1);
    chk("rb1_flush", 32'(flush), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    $display("reboot cycle 2: we=%b nxt=%h hold=%b flush=%b", pc_we, pc_next, hold, flush);
    chk("rb2_we", 32'(pc_we), 32'd1);
    chk("rb2_nxt", pc_next, RESET_PC);
    chk("rb2_flush", 32'(flush), 32'd1);
    @(posedge clk); #1;

    // randomized run against the model
    m_mode = "BOOT"; m_boot = 0; m_fault = 0; m_cause = 0; m_fpc = 0; m_scnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp, pc;
      pc = $urandom;
      if ($urandom_range(0, 15) != 0) pc[1:0] = 2'b00;
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFFFFFC;
      rp = $urandom;
      if ($urandom_range(0, 7) != 0) rp[1:0] = 2'b00;
      set_in((i < 2) ? 1'b0 : ($urandom_range(0, 199) != 0), pc,
             $urandom_range(0, 15) != 0,
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, rp, $urandom_range(0, 3) == 0);
      model_eval();
      @(negedge clk);
      $display("rnd %0d mode=%s rst=%b pc=%h v=%b s=%b rq=%b we=%b nxt=%h hold=%b flush=%b fault=%b",
               i, m_mode, rst, pc_curr, valid, dec_stall, redir_req, pc_we, pc_next, hold, flush, fault);
      chk($sformatf("r%0d_we", i), 32'(pc_we), 32'(e_we));
      if (rst) chk($sformatf("r%0d_nxt", i), pc_next, e_nxt);
      chk($sformatf("r%0d_hold", i), 32'(hold), 32'(e_hold));
      chk($sformatf("r%0d_flush", i), 32'(flush), 32'(e_flush));
      chk($sformatf("r%0d_fault", i), 32'(fault), 32'(m_fault));
      chk($sformatf("r%0d_cause", i), 32'(fault_cause), 32'(m_cause));
      chk($sformatf("r%0d_fpc", i), fault_pc, m_fpc);
      chk($sformatf("r%0d_scnt", i), 32'(stall_cnt), 32'(m_scnt));
      model_commit();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
